// File: rtl/NXConstants.sv
// NXConstants: shared node message types and constants for the node decoder.
// node_message_t is the raw 29-bit inbound message. node_signal_t and
// node_load_t are its two views, and both keep the command header in the top bits.
package NXConstants;
    localparam int MSG_W = 29;
    typedef enum logic [1:0] {
        NODE_COMMAND_SIGNAL = 2'd0,
        NODE_COMMAND_LOAD   = 2'd1,
        NODE_COMMAND_RSVD_2 = 2'd2,
        NODE_COMMAND_RSVD_3 = 2'd3
    } node_command_t;
    typedef enum logic [1:0] {SLOT_PRESERVE, SLOT_INVERSE, SLOT_LOWER, SLOT_UPPER} node_slot_t;
    typedef enum logic {IDLE, HOLD} decoder_state_t;
    typedef struct packed {
        node_command_t command;
    } node_header_t;
    typedef struct packed {
        node_header_t header;
        logic [10:0]  address;
        node_slot_t   slot;
        logic [7:0]   data;
        logic [5:0]   pad;
    } node_signal_t;
    typedef struct packed {
        node_header_t header;
        logic [9:0]   address;
        logic         half;
        logic [15:0]  data;
    } node_load_t;
    typedef logic [MSG_W-1:0] node_message_t;
endpackage

// File: rtl/nx_node_decoder_if.sv
// nx_node_decoder_if: inbound message handshake.
// Ports: i_msg_data (message), i_msg_valid (offered), o_msg_ready (decoder can take it).
// The master drives the message and the slave is the decoder.
interface nx_node_decoder_if;
    import NXConstants::*;
    node_message_t i_msg_data;
    logic          i_msg_valid;
    logic          o_msg_ready;
    modport master(output i_msg_data, i_msg_valid, input o_msg_ready);
    modport slave(input i_msg_data, i_msg_valid, output o_msg_ready);
endinterface

// File: rtl/nx_node_decoder_lane.sv
// nx_node_decoder_lane: maps a SIGNAL message onto a data RAM word, byte lane and strobe.
// Ports: i_address, i_slot_mode, i_slot, i_data in; o_word_addr, o_strb (bit strobes),
// o_data (byte replicated 4x) out. The block is purely combinational.
module nx_node_decoder_lane
    import NXConstants::*;
(
    input  logic [10:0] i_address,
    input  node_slot_t  i_slot_mode,
    input  logic        i_slot,
    input  logic [7:0]  i_data,
    output logic [9:0]  o_word_addr,
    output logic [31:0] o_strb,
    output logic [31:0] o_data
);
    logic       slot_bit;
    logic [1:0] lane;
    always_comb begin
        slot_bit    = i_slot_mode == SLOT_PRESERVE ? i_slot :
                      i_slot_mode == SLOT_INVERSE  ? !i_slot : i_slot_mode == SLOT_UPPER;
        lane        = {i_address[0], slot_bit};
        o_word_addr = i_address[10:1];
        o_strb      = 32'hFF << {lane, 3'b000};
        o_data      = {4{i_data}};
    end
endmodule

// File: rtl/nx_node_decoder.sv
// nx_node_decoder: decodes node messages into data RAM and instruction RAM writes.
// Ports: i_clk, i_rst (async, active-low), msg (message handshake, slave), i_slot, i_idle,
// i_data_busy. Outputs are the data RAM write port o_data_*, the instruction RAM write port
// o_inst_*, and the sticky o_load_error.
// Build option: define NX_NODE_DECODER_LOAD_EN to enable LOAD handling. When it is not
// defined, LOAD is consumed like an unknown command.
module nx_node_decoder
    import NXConstants::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    nx_node_decoder_if.slave      msg,
    input  logic                  i_slot,
    input  logic                  i_idle,
    input  logic                  i_data_busy,
    output logic [9:0]            o_data_addr,
    output logic [31:0]           o_data_wr_data,
    output logic [31:0]           o_data_wr_strb,
    output logic                  o_data_wr_en,
    output logic [9:0]            o_inst_addr,
    output logic [31:0]           o_inst_wr_data,
    output logic                  o_inst_wr_en,
    output logic                  o_load_error
);
    decoder_state_t state, next_state;
    node_message_t  held;
    node_signal_t   sig;
    node_command_t  cmd;
    logic           hold, data_go, load_stall, retire, accept, unused_ok;
    logic [9:0]     word_addr;
    logic [31:0]    lane_strb, lane_data;
    assign sig  = node_signal_t'(held);
    assign cmd  = sig.header.command;
    assign hold = state == HOLD;
    nx_node_decoder_lane u_lane (
        .i_address  (sig.address),
        .i_slot_mode(sig.slot),
        .i_slot     (i_slot),
        .i_data     (sig.data),
        .o_word_addr(word_addr),
        .o_strb     (lane_strb),
        .o_data     (lane_data)
    );
`ifdef NX_NODE_DECODER_LOAD_EN
    node_load_t  ld;
    logic        is_load, inst_go, match, lower_valid;
    logic [9:0]  lower_addr;
    logic [15:0] lower_data;
    assign ld         = node_load_t'(held);
    assign is_load    = hold && cmd == NODE_COMMAND_LOAD;
    assign match      = lower_valid && lower_addr == ld.address;
    assign inst_go    = is_load && ld.half && i_idle;
    assign load_stall = is_load && ld.half && !i_idle;
    assign unused_ok  = ^sig.pad;
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            lower_valid  <= 1'b0;
            lower_addr   <= '0;
            lower_data   <= '0;
            o_load_error <= 1'b0;
        end else if (is_load && !ld.half) begin
            lower_valid <= 1'b1;
            lower_addr  <= ld.address;
            lower_data  <= ld.data;
        end else if (inst_go) begin
            lower_valid <= 1'b0;
            if (!match) o_load_error <= 1'b1;
        end
    always_comb begin
        o_inst_wr_en   = inst_go;
        o_inst_addr    = inst_go ? ld.address : '0;
        o_inst_wr_data = inst_go ? {ld.data, match ? lower_data : 16'h0} : '0;
    end
`else
    assign load_stall     = 1'b0;
    assign unused_ok      = ^{i_idle, sig.pad};
    assign o_inst_wr_en   = 1'b0;
    assign o_inst_addr    = '0;
    assign o_inst_wr_data = '0;
    assign o_load_error   = 1'b0;
`endif
    // The held message retires this cycle unless it waits for the data RAM or for core idle.
    // A new message can then be accepted in the same cycle.
    always_comb begin
        data_go         = hold && cmd == NODE_COMMAND_SIGNAL && !i_data_busy;
        retire          = hold && !(cmd == NODE_COMMAND_SIGNAL && i_data_busy) && !load_stall;
        msg.o_msg_ready = i_rst && (!hold || retire);
        accept          = msg.i_msg_valid && msg.o_msg_ready;
        next_state      = accept ? HOLD : retire ? IDLE : state;
        o_data_wr_en    = data_go;
        o_data_addr     = data_go ? word_addr : '0;
        o_data_wr_data  = data_go ? lane_data : '0;
        o_data_wr_strb  = data_go ? lane_strb : '0;
    end
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            state <= next_state;
            if (accept) held <= msg.i_msg_data;
        end
endmodule
